operand_fetch: RTL

Operand-fetch stage placed directly upstream of the ALU. Holds the 32-entry general-purpose register file, reads two source registers with same-cycle writeback bypass, and applies immediate selection and extension. Registers the ALU operands, shift amount and ALU control code into the ID/EX pipeline register that drives the ALU inputs. Stall and flush controls come from the hazard/branch logic.

---
 rtl/operand_fetch.sv | 105 ++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32-entry register file with writeback bypass, immediate
// extension, and the ID/EX pipeline register feeding the ALU.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic [15:0]       id_imm,
  input  logic              id_use_imm,
  input  logic              id_sign_ext,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_aluctrl,
  input  logic [AW-1:0]     id_dst,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [4:0]        ex_shamt,
  output logic [3:0]        ex_aluctrl,
  output logic [AW-1:0]     ex_dst,
  output logic [DATA_W-1:0] ex_rt_data
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] rt_data;
    logic [4:0]        shamt;
    logic [3:0]        aluctrl;
    logic [AW-1:0]     dst;
  } idex_t;

  logic [DATA_W-1:0] r_rf [NREGS];
  idex_t             r_idex;
  idex_t             w_idex_nxt;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_ext;
  logic              w_wb_live;

  assign w_wb_live = wb_en && (wb_addr != '0);

  // Register file write proceeds regardless of stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_live) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback is bypassed so there is no write-to-read delay.
  always_comb begin
    w_rs_val = r_rf[id_rs];
    if (id_rs == '0)                     w_rs_val = '0;
    else if (wb_en && wb_addr == id_rs)  w_rs_val = wb_data;
    w_rt_val = r_rf[id_rt];
    if (id_rt == '0)                     w_rt_val = '0;
    else if (wb_en && wb_addr == id_rt)  w_rt_val = wb_data;
  end

  assign w_ext = id_sign_ext ? {{(DATA_W-16){id_imm[15]}}, id_imm}
                             : {{(DATA_W-16){1'b0}}, id_imm};

  always_comb begin
    w_idex_nxt = '0;
    if (flush) begin
      w_idex_nxt = '0;
    end else if (stall) begin
      w_idex_nxt = r_idex;
    end else if (id_valid) begin
      w_idex_nxt.vld     = 1'b1;
      w_idex_nxt.in1     = w_rs_val;
      w_idex_nxt.in2     = id_use_imm ? w_ext : w_rt_val;
      w_idex_nxt.rt_data = w_rt_val;
      w_idex_nxt.shamt   = id_shamt;
      w_idex_nxt.aluctrl = id_aluctrl;
      w_idex_nxt.dst     = id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idex <= '0;
    else        r_idex <= w_idex_nxt;
  end

  assign ex_valid   = r_idex.vld;
  assign ex_in1     = r_idex.in1;
  assign ex_in2     = r_idex.in2;
  assign ex_rt_data = r_idex.rt_data;
  assign ex_shamt   = r_idex.shamt;
  assign ex_aluctrl = r_idex.aluctrl;
  assign ex_dst     = r_idex.dst;

endmodule
